// File: rtl/t_ff_pkg.sv
// -----------------------------------------------------------------------------
// t_ff_pkg
//   Shared definitions for the T flip-flop register bank.
//   Holds the mode encodings used on the 2-bit mode port of t_ff_counter.
// -----------------------------------------------------------------------------
package t_ff_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_LOAD   = 2'b11
    } t_ff_mode_e;

    // True for the modes that can hit a count bound.
    function automatic logic is_count_mode(input logic [1:0] m);
        return (m == MODE_UP) || (m == MODE_DOWN);
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// -----------------------------------------------------------------------------
// t_ff_cell
//   A single T flip-flop with synchronous active-low reset.
// Ports
//   clk      in  rising-edge clock
//   rst      in  synchronous reset, active-low (loads rst_val)
//   en       in  step enable; 0 holds the state
//   t        in  toggle request for this bit
//   rst_val  in  value taken on reset
//   q        out flip-flop state
// -----------------------------------------------------------------------------
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= rst_val;
        end else if (en && t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_ff_counter.sv
// -----------------------------------------------------------------------------
// t_ff_counter
//   Parametrised bank of WIDTH T flip-flops. The per-bit toggle vector is
//   selected by mode: raw toggle mask, up-count, down-count or parallel load.
//   Counting either wraps or saturates at the bound (SATURATE).
// Parameters
//   WIDTH     number of bits (>= 2)
//   RST_VAL   value of q after reset
//   SATURATE  1: hold at the bound; 0: wrap around
// Ports
//   clk       in  rising-edge clock
//   rst       in  synchronous reset, active-low
//   en        in  step enable; 0 holds all state
//   mode      in  00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD
//   t         in  toggle mask (TOGGLE)
//   d         in  load value (LOAD)
//   clr_flag  in  clears the sticky bound flag
//   q         out register state
//   tc        out terminal-count pulse, one cycle after a bound event
//   bound     out sticky bound-event flag
// -----------------------------------------------------------------------------
module t_ff_counter
    import t_ff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             bound
);

    logic [WIDTH-1:0] up_vec;
    logic [WIDTH-1:0] dn_vec;
    logic [WIDTH-1:0] tvec;
    logic             at_bound;
    logic             bound_event;

    // Carry/borrow chains: bit i toggles when every lower bit is 1 (up)
    // or every lower bit is 0 (down).
    always_comb begin
        up_vec    = '0;
        dn_vec    = '0;
        up_vec[0] = 1'b1;
        dn_vec[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_vec[i] = up_vec[i-1] & q[i-1];
            dn_vec[i] = dn_vec[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        at_bound = 1'b0;
        if (mode == MODE_UP) begin
            at_bound = &q;
        end else if (mode == MODE_DOWN) begin
            at_bound = ~|q;
        end
    end

    assign bound_event = en && is_count_mode(mode) && at_bound;

    always_comb begin
        tvec = '0;
        case (mode)
            MODE_TOGGLE: tvec = t;
            MODE_UP:     tvec = up_vec;
            MODE_DOWN:   tvec = dn_vec;
            MODE_LOAD:   tvec = q ^ d;
            default:     tvec = '0;
        endcase
        // Saturating counters suppress the wrap toggle so q stays at the bound.
        if (SATURATE && bound_event) begin
            tvec = '0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .t       (tvec[i]),
            .rst_val (RST_VAL[i]),
            .q       (q[i])
        );
    end

    // Flag registers: a same-edge bound event takes priority over clr_flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tc    <= 1'b0;
            bound <= 1'b0;
        end else begin
            tc <= bound_event;
            if (bound_event) begin
                bound <= 1'b1;
            end else if (clr_flag) begin
                bound <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_t_ff_counter.sv
module tb_t_ff_counter;
    import t_ff_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] t = '0;
    logic [W-1:0] d = '0;
    logic         clr_flag = 1'b0;
    logic [W-1:0] q_w, q_s;
    logic         tc_w, tc_s, bound_w, bound_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    t_ff_counter #(.WIDTH(W), .RST_VAL(4'b0000), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
        .clr_flag(clr_flag), .q(q_w), .tc(tc_w), .bound(bound_w)
    );

    t_ff_counter #(.WIDTH(W), .RST_VAL(4'b0000), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
        .clr_flag(clr_flag), .q(q_s), .tc(tc_s), .bound(bound_s)
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic [1:0]   mode;
        logic [W-1:0] t;
        logic [W-1:0] d;
        logic         clr;
        logic [W-1:0] eq;
        logic         etc;
        logic         eb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] tt, input logic [W-1:0] dd, input logic c);
        rst = r; en = e; mode = m; t = tt; d = dd; clr_flag = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst en mode t d clr | q tc bound  (wrapping instance)
        vecs.push_back('{1'b0, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_LOAD,   4'h0, 4'hE, 1'b0, 4'hE, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_LOAD,   4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_TOGGLE, 4'hA, 4'h0, 1'b0, 4'hA, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_TOGGLE, 4'h3, 4'h0, 1'b0, 4'h9, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_LOAD,   4'h0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_TOGGLE, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_DOWN,   4'h0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_DOWN,   4'h0, 4'h0, 1'b0, 4'hE, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, MODE_TOGGLE, 4'h0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_LOAD,   4'h0, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_LOAD,   4'h0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_LOAD,   4'h0, 4'h3, 1'b0, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, MODE_UP,     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].t, vecs[i].d, vecs[i].clr);
            chk($sformatf("vec%0d_q", i),     int'(q_w),     int'(vecs[i].eq));
            chk($sformatf("vec%0d_tc", i),    int'(tc_w),    int'(vecs[i].etc));
            chk($sformatf("vec%0d_bound", i), int'(bound_w), int'(vecs[i].eb));
        end

        // Saturating instance: reset, load 0001, then DOWN three times.
        step(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 1'b0);
        chk("sat_rst_q", int'(q_s), 0);
        chk("sat_rst_bound", int'(bound_s), 0);
        step(1'b1, 1'b1, MODE_LOAD, 4'h0, 4'h1, 1'b0);
        chk("sat_load_q", int'(q_s), 1);
        step(1'b1, 1'b1, MODE_DOWN, 4'h0, 4'h0, 1'b0);
        chk("sat_dn1_q", int'(q_s), 0);
        chk("sat_dn1_tc", int'(tc_s), 0);
        chk("sat_dn1_bound", int'(bound_s), 0);
        for (int k = 2; k <= 3; k++) begin
            step(1'b1, 1'b1, MODE_DOWN, 4'h0, 4'h0, 1'b0);
            chk($sformatf("sat_dn%0d_q", k), int'(q_s), 0);
            chk($sformatf("sat_dn%0d_tc", k), int'(tc_s), 1);
            chk($sformatf("sat_dn%0d_bound", k), int'(bound_s), 1);
        end
        // Upper bound also holds when saturating.
        step(1'b1, 1'b1, MODE_LOAD, 4'h0, 4'hF, 1'b1);
        chk("sat_loadf_bound", int'(bound_s), 0);
        step(1'b1, 1'b1, MODE_UP, 4'h0, 4'h0, 1'b0);
        chk("sat_up_q", int'(q_s), 15);
        chk("sat_up_tc", int'(tc_s), 1);
        chk("sat_up_bound", int'(bound_s), 1);
        step(1'b1, 1'b1, MODE_TOGGLE, 4'h0, 4'h0, 1'b0);
        chk("sat_tc_drop", int'(tc_s), 0);
        chk("sat_hold_q", int'(q_s), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
